// File: rtl/lenet_pkg.sv
// Shared constants, mode/state encodings and side decode for the LeNet conv path.
package lenet_pkg;

  localparam int unsigned DATA_WIDTH        = 8;
  localparam int unsigned MAX_WIDTH         = 32;
  localparam int unsigned CW                = $clog2(MAX_WIDTH);
  // One extra bit so the side value itself (up to MAX_WIDTH) is representable
  localparam int unsigned SW                = CW + 1;
  localparam int unsigned FEATURE_MAP1_SIZE = 32;
  localparam int unsigned FEATURE_MAP2_SIZE = 28;
  localparam int unsigned FEATURE_MAP3_SIZE = 14;
  localparam int unsigned FEATURE_MAP4_SIZE = 10;
  localparam int unsigned FEATURE_MAP5_SIZE = 5;
  localparam int unsigned KERNEL            = 5;
  localparam int unsigned WIN_CNT_W         = 10;

  typedef enum logic [2:0] {
    MODE_FM1 = 3'b000,
    MODE_FM2 = 3'b001,
    MODE_FM3 = 3'b010,
    MODE_FM4 = 3'b011,
    MODE_FM5 = 3'b100
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Feature-map side for a layer mode; unknown encodings fall back to the largest map
  function automatic logic [SW-1:0] fm_side(input logic [2:0] m);
    case (m)
      MODE_FM1: fm_side = SW'(FEATURE_MAP1_SIZE);
      MODE_FM2: fm_side = SW'(FEATURE_MAP2_SIZE);
      MODE_FM3: fm_side = SW'(FEATURE_MAP3_SIZE);
      MODE_FM4: fm_side = SW'(FEATURE_MAP4_SIZE);
      MODE_FM5: fm_side = SW'(FEATURE_MAP5_SIZE);
      default:  fm_side = SW'(FEATURE_MAP1_SIZE);
    endcase
  endfunction

endpackage

// File: rtl/lb_raster_cnt.sv
// Raster row/column counter over a square map of side side_i, with wrap and last-row flags.
module lb_raster_cnt
  import lenet_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [SW-1:0] side_i,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          wrap_o,
  output logic          row_last_o
);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [SW-1:0] side_m1;
  logic          col_last;

  assign side_m1    = side_i - SW'(1);
  assign col_last   = ({1'b0, col_q} == side_m1);
  assign row_last_o = ({1'b0, row_q} == side_m1);
  assign wrap_o     = en_i & col_last;
  assign row_o      = row_q;
  assign col_o      = col_q;

  // Next position: column wraps at side-1 then row advances; last pixel returns to origin
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last_o ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/lb_window_ctrl.sv
// Frame sequencer for the 5-row line buffer: streams pixels in, flags complete 5x5 windows.
module lb_window_ctrl
  import lenet_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            mode,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  lb_en,
  output logic [DATA_WIDTH-1:0] lb_data,
  output logic [2:0]            lb_mode,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [CW-1:0]         win_row,
  output logic [CW-1:0]         win_col,
  output logic [WIN_CNT_W-1:0]  win_cnt,
  output logic                  busy,
  output logic                  frame_done
);

  state_e               state_q;
  logic [2:0]           mode_q;
  logic [SW-1:0]        side_q;
  logic                 win_valid_q;
  logic [CW-1:0]        win_row_q;
  logic [CW-1:0]        win_col_q;
  logic [WIN_CNT_W-1:0] win_cnt_q;
  logic                 frame_done_q;

  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic          wrap;
  logic          row_last;
  logic          accept;
  logic          start_acc;
  logic          win_hit;
  logic          win_hs;

  // A pending unaccepted window stalls the stream so the buffer columns stay put
  assign s_ready   = (state_q == RUN) & ~(win_valid_q & ~win_ready);
  assign accept    = s_valid & s_ready;
  assign start_acc = (state_q == IDLE) & start & ~abort;
  assign win_hs    = win_valid_q & win_ready;
  assign win_hit   = accept & (row >= CW'(KERNEL - 1)) & (col >= CW'(KERNEL - 1));

  assign lb_en      = accept;
  assign lb_data    = s_data;
  assign lb_mode    = mode_q;
  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign win_cnt    = win_cnt_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

  lb_raster_cnt u_raster (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (abort | start_acc),
    .en_i       (accept),
    .side_i     (side_q),
    .row_o      (row),
    .col_o      (col),
    .wrap_o     (wrap),
    .row_last_o (row_last)
  );

  // Frame FSM plus window flag/coordinates/count; abort overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= 3'b000;
      side_q       <= SW'(FEATURE_MAP1_SIZE);
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else if (abort) begin
      state_q      <= IDLE;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (win_hit) begin
        win_valid_q <= 1'b1;
        win_row_q   <= row - CW'(KERNEL - 1);
        win_col_q   <= col - CW'(KERNEL - 1);
      end else if (win_hs) begin
        win_valid_q <= 1'b0;
      end
      if (win_hs && (win_cnt_q != '1)) begin
        win_cnt_q <= win_cnt_q + WIN_CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            side_q    <= fm_side(mode);
            win_cnt_q <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (wrap && row_last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!win_valid_q || win_hs) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lb_window_ctrl.sv
// Directed bench for lb_window_ctrl: frame sequencing, windows, stall, abort, reset.
module tb_lb_window_ctrl;
  import lenet_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [2:0]            mode = 3'b000;
  logic                  abort = 1'b0;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data = '0;
  logic                  lb_en;
  logic [DATA_WIDTH-1:0] lb_data;
  logic [2:0]            lb_mode;
  logic                  win_valid;
  logic                  win_ready = 1'b1;
  logic [CW-1:0]         win_row;
  logic [CW-1:0]         win_col;
  logic [WIN_CNT_W-1:0]  win_cnt;
  logic                  busy;
  logic                  frame_done;

  int n_chk = 0;
  int n_pass = 0;
  int cur_w = 5;

  // Monitor state, cleared on every accepted start
  int cyc = 0;
  int mon_pix = 0;
  int first_win_pix = -1;
  int wv_cycles = 0;
  int hs_cnt = 0;
  int mon_err = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int last_pix_cyc = 0;
  int exp_r = 0;
  int exp_c = 0;
  logic seen_win = 1'b0;
  logic [CW-1:0] first_r = '0, first_c = '0, last_r = '0, last_c = '0;

  lb_window_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .lb_en      (lb_en),
    .lb_data    (lb_data),
    .lb_mode    (lb_mode),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_row    (win_row),
    .win_col    (win_col),
    .win_cnt    (win_cnt),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference raster of window positions, checked on every handshake
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start && !busy) begin
      mon_pix       <= 0;
      first_win_pix <= -1;
      wv_cycles     <= 0;
      hs_cnt        <= 0;
      mon_err       <= 0;
      fd_cnt        <= 0;
      exp_r         <= 0;
      exp_c         <= 0;
      seen_win      <= 1'b0;
    end else begin
      if (lb_en) begin
        mon_pix      <= mon_pix + 1;
        last_pix_cyc <= cyc;
      end
      if (win_valid) begin
        wv_cycles <= wv_cycles + 1;
        if (!seen_win) begin
          seen_win      <= 1'b1;
          first_win_pix <= mon_pix;
          first_r       <= win_row;
          first_c       <= win_col;
        end
      end
      if (win_valid && win_ready) begin
        hs_cnt <= hs_cnt + 1;
        last_r <= win_row;
        last_c <= win_col;
        if ((int'(win_row) != exp_r) || (int'(win_col) != exp_c)) mon_err <= mon_err + 1;
        if (exp_c == cur_w - 5) begin
          exp_c <= 0;
          exp_r <= exp_r + 1;
        end else begin
          exp_c <= exp_c + 1;
        end
      end
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        fd_cyc <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [2:0] m, input int w);
    cur_w = w;
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer n pixels at pct% density; optionally hold win_ready low 3 cycles on window stall_win
  task automatic stream(input int n, input int pct, input int stall_win, input int max_cyc);
    int sent = 0;
    int cycles = 0;
    logic stalled = 1'b0;
    while (sent < n && cycles < max_cyc) begin
      if (stall_win >= 0 && !stalled && win_valid && hs_cnt == stall_win) begin
        win_ready = 1'b0;
        s_valid   = 1'b1;
        s_data    = DATA_WIDTH'(sent);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_s_ready", 32'(s_ready), 0);
          chk("stall_lb_en", 32'(lb_en), 0);
          chk("stall_win_valid", 32'(win_valid), 1);
          chk("stall_win_row", 32'(win_row), 0);
          chk("stall_win_col", 32'(win_col), 4);
          tick();
        end
        win_ready = 1'b1;
        stalled   = 1'b1;
      end
      s_valid = (int'($urandom_range(99)) < pct);
      s_data  = DATA_WIDTH'(sent);
      @(negedge clk);
      if (lb_en) sent++;
      tick();
      cycles++;
    end
    s_valid = 1'b0;
    chk("stream_all_accepted", sent, n);
  endtask

  task automatic wait_done(input int max_cyc);
    int c = 0;
    while (fd_cnt == 0 && c < max_cyc) begin
      tick();
      c++;
    end
    chk("frame_done_seen", fd_cnt, 1);
  endtask

  initial begin
    // Reset values, including with s_valid offered
    s_valid = 1'b1;
    s_data  = 8'hA5;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_lb_en", 32'(lb_en), 0);
    chk("rst_win_valid", 32'(win_valid), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_lb_mode", 32'(lb_mode), 0);
    chk("rst_win_cnt", 32'(win_cnt), 0);
    chk("rst_win_row", 32'(win_row), 0);
    chk("rst_win_col", 32'(win_col), 0);
    chk("lb_data_pass", 32'(lb_data), 32'hA5);
    rst_n = 1'b1;
    tick();
    chk("idle_no_consume", 32'(lb_en), 0);
    s_valid = 1'b0;

    // Mode 3'b100: single window
    start_frame(3'b100, 5);
    chk("fm5_busy", 32'(busy), 1);
    chk("fm5_lb_mode", 32'(lb_mode), 4);
    stream(25, 100, -1, 200);
    wait_done(20);
    chk("fm5_hs", hs_cnt, 1);
    chk("fm5_wv_cycles", wv_cycles, 1);
    chk("fm5_first_pix", first_win_pix, 25);
    chk("fm5_first_row", 32'(first_r), 0);
    chk("fm5_first_col", 32'(first_c), 0);
    chk("fm5_done_latency", fd_cyc - last_pix_cyc, 2);
    chk("fm5_win_cnt", 32'(win_cnt), 1);
    tick();
    chk("fm5_idle", 32'(busy), 0);
    chk("fm5_done_once", fd_cnt, 1);

    // Mode 3'b000: full 32x32 map
    start_frame(3'b000, 32);
    stream(1024, 100, -1, 3000);
    wait_done(20);
    chk("fm1_hs", hs_cnt, 784);
    chk("fm1_win_cnt", 32'(win_cnt), 784);
    chk("fm1_first_pix", first_win_pix, 133);
    chk("fm1_first_row", 32'(first_r), 0);
    chk("fm1_first_col", 32'(first_c), 0);
    chk("fm1_last_row", 32'(last_r), 27);
    chk("fm1_last_col", 32'(last_c), 27);
    chk("fm1_order", mon_err, 0);

    // Mode 3'b011 with a 3-cycle stall on the 5th window
    start_frame(3'b011, 10);
    stream(100, 100, 4, 1000);
    wait_done(20);
    chk("fm4_hs", hs_cnt, 36);
    chk("fm4_win_cnt", 32'(win_cnt), 36);
    chk("fm4_order", mon_err, 0);

    // Mode 3'b010 with random gaps
    start_frame(3'b010, 14);
    stream(196, 50, -1, 5000);
    wait_done(20);
    chk("fm3_hs", hs_cnt, 100);
    chk("fm3_win_cnt", 32'(win_cnt), 100);
    chk("fm3_order", mon_err, 0);
    chk("fm3_last_row", 32'(last_r), 9);
    chk("fm3_last_col", 32'(last_c), 9);

    // Abort at pixel 300 of mode 3'b001, then a clean 3'b100 frame
    start_frame(3'b001, 28);
    stream(300, 100, -1, 1000);
    abort   = 1'b1;
    s_valid = 1'b1;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_win_valid", 32'(win_valid), 0);
    chk("abort_s_ready", 32'(s_ready), 0);
    chk("abort_win_cnt", 32'(win_cnt), 0);
    repeat (4) tick();
    chk("abort_no_done", fd_cnt, 0);
    start_frame(3'b100, 5);
    stream(25, 100, -1, 200);
    wait_done(20);
    chk("post_abort_hs", hs_cnt, 1);
    chk("post_abort_win_cnt", 32'(win_cnt), 1);

    // Start and mode changes mid-frame are ignored
    repeat (2) tick();
    start_frame(3'b011, 10);
    stream(30, 100, -1, 200);
    mode  = 3'b000;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = 3'b001;
    chk("midstart_lb_mode", 32'(lb_mode), 3);
    chk("midstart_busy", 32'(busy), 1);
    stream(70, 100, -1, 500);
    chk("midmode_lb_mode", 32'(lb_mode), 3);
    wait_done(20);
    chk("midstart_hs", hs_cnt, 36);
    chk("midstart_win_cnt", 32'(win_cnt), 36);

    // Asynchronous reset mid-RUN with a window pending
    repeat (2) tick();
    start_frame(3'b001, 28);
    stream(150, 100, -1, 500);
    chk("prerst_win_valid", 32'(win_valid), 1);
    chk("prerst_lb_mode", 32'(lb_mode), 1);
    s_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_s_ready", 32'(s_ready), 0);
    chk("arst_lb_en", 32'(lb_en), 0);
    chk("arst_win_valid", 32'(win_valid), 0);
    chk("arst_win_row", 32'(win_row), 0);
    chk("arst_win_col", 32'(win_col), 0);
    chk("arst_win_cnt", 32'(win_cnt), 0);
    chk("arst_lb_mode", 32'(lb_mode), 0);
    chk("arst_frame_done", 32'(frame_done), 0);
    s_valid = 1'b0;
    #10;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
